// File: rtl/glb_stream_arbiter.sv
// Round-robin arbiter that grants one tile stream per block (header + payload) onto a shared
// GLB read-sink port; sequencing starts on flush falling and ends once every stream has finished.
module glb_stream_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 17,
   parameter int NUM_BLOCKS = 1,
   parameter int MAX_SIZE   = 2048
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(NUM_REQ)-1:0] out_sel,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic [NUM_REQ-1:0]         req_done,
   output logic                       done,
   output logic                       err_oversize
);
   localparam int SEL_W = $clog2(NUM_REQ);
   localparam int BLK_W = $clog2(NUM_BLOCKS + 1);
   localparam logic [DATA_W-1:0] MAX_SIZE_V = DATA_W'(MAX_SIZE);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARB  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_BODY = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         r_state;
   logic               r_flush_q;
   logic [SEL_W-1:0]   r_rr_ptr;
   logic [SEL_W-1:0]   r_grant;
   logic [DATA_W-1:0]  r_size;
   logic [DATA_W-1:0]  r_beat_cnt;
   logic [DATA_W-1:0]  r_data_hold;
   logic [BLK_W-1:0]   r_blk_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] r_req_done;
   logic               r_done;
   logic               r_err;

   logic [DATA_W-1:0]  w_req_arr [NUM_REQ];
   logic [SEL_W-1:0]   w_idx [NUM_REQ];
   logic [NUM_REQ-1:0] w_cand;
   logic               w_found;
   logic [SEL_W-1:0]   w_winner;
   logic [SEL_W-1:0]   w_rr_next;
   logic [NUM_REQ-1:0] w_grant_oh;
   logic [DATA_W-1:0]  w_gdata;
   logic               w_gvalid;
   logic               w_active;
   logic               w_hs;
   logic               w_last;
   logic               w_blk_end;
   logic [BLK_W-1:0]   w_blk_nxt;
   logic               w_blk_full;
   logic [NUM_REQ-1:0] w_req_done_nxt;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   assign w_cand         = req_valid & ~r_req_done;
   assign w_rr_next      = (w_winner == SEL_W'(NUM_REQ - 1)) ? '0 : w_winner + SEL_W'(1);
   assign w_grant_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
   assign w_gdata        = w_req_arr[r_grant];
   assign w_gvalid       = req_valid[r_grant];
   assign w_active       = ((r_state == S_HDR) || (r_state == S_BODY)) && !flush;
   assign w_hs           = w_active && w_gvalid && out_ready;
   assign w_blk_end      = w_hs && w_last;
   assign w_blk_nxt      = r_blk_cnt[r_grant] + BLK_W'(1);
   assign w_blk_full     = (w_blk_nxt == BLK_W'(NUM_BLOCKS));
   assign w_req_done_nxt = r_req_done | (w_blk_full ? w_grant_oh : '0);

   assign out_valid    = w_active && w_gvalid;
   assign req_ready    = w_active ? (w_grant_oh & {NUM_REQ{out_ready}}) : '0;
   assign out_data     = w_active ? w_gdata : r_data_hold;
   assign out_sel      = r_grant;
   assign out_sop      = w_active && (r_state == S_HDR);
   assign out_eop      = w_active && w_last;
   assign req_done     = r_req_done;
   assign done         = r_done;
   assign err_oversize = r_err;

   // Search order starting at the round-robin pointer, wrapping around.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx[k] = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
   end

   // First eligible requester in search order wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_cand[w_idx[k]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[k];
         end else begin
            w_found  = w_found;
            w_winner = w_winner;
         end
      end
   end

   // A zero-size header is itself the last beat of its block.
   always_comb begin
      if (r_state == S_HDR) begin
         w_last = (w_gdata == '0);
      end else begin
         w_last = (r_beat_cnt == r_size - DATA_W'(1));
      end
   end

   // Sequencer state, per-requester progress and sticky status; flush acts as a soft reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_flush_q   <= 1'b0;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_size      <= '0;
         r_beat_cnt  <= '0;
         r_data_hold <= '0;
         r_req_done  <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) r_blk_cnt[i] <= '0;
      end else begin
         r_flush_q <= flush;
         if (w_active) r_data_hold <= w_gdata;
         if (flush) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_req_done <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) r_blk_cnt[i] <= '0;
         end else begin
            case (r_state)
               S_IDLE: r_state <= r_flush_q ? S_ARB : S_IDLE;
               S_ARB: begin
                  if (w_found) begin
                     r_grant  <= w_winner;
                     r_rr_ptr <= w_rr_next;
                     r_state  <= S_HDR;
                  end
               end
               S_HDR: begin
                  if (w_hs) begin
                     r_size     <= w_gdata;
                     r_beat_cnt <= '0;
                     if (w_gdata > MAX_SIZE_V) r_err <= 1'b1;
                     if (!w_last) r_state <= S_BODY;
                  end
               end
               S_BODY: if (w_hs) r_beat_cnt <= r_beat_cnt + DATA_W'(1);
               S_DONE: r_state <= S_DONE;
               default: r_state <= S_IDLE;
            endcase
            if (w_blk_end) begin
               r_blk_cnt[r_grant] <= w_blk_nxt;
               r_req_done         <= w_req_done_nxt;
               if (&w_req_done_nxt) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_ARB;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_glb_stream_arbiter.sv
// Directed bench for glb_stream_arbiter: per-requester beat queues feed the DUT and every
// forwarded handshake is logged, then compared with hand-computed expectations.
module tb_glb_stream_arbiter;
   localparam int NR = 4;
   localparam int DW = 17;

   logic               clk = 1'b0;
   logic               rst_n, flush, out_ready;
   logic [NR*DW-1:0]   req_data;
   logic [NR-1:0]      req_valid, req_ready, req_done;
   logic [DW-1:0]      out_data;
   logic               out_valid, out_sop, out_eop, done, err_oversize;
   logic [1:0]         out_sel;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [1:0]    sel;
      logic          sop;
      logic          eop;
      int            cyc;
   } beat_t;

   beat_t         log_q [$];
   logic [DW-1:0] src_q [NR][$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            done_cyc = -1;
   int            viol = 0;
   logic          rand_rdy = 1'b0;
   logic          s_valid;
   logic [NR-1:0] s_rdy;

   always #5 clk = ~clk;

   glb_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .NUM_BLOCKS(1), .MAX_SIZE(2048)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_data(req_data), .req_valid(req_valid),
      .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel), .out_sop(out_sop), .out_eop(out_eop), .req_done(req_done),
      .done(done), .err_oversize(err_oversize));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, sample #1 later, log handshakes, then wait for posedge.
   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = src_q[i][0];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
      out_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      s_valid = out_valid;
      s_rdy   = req_ready;
      if ((req_ready & ~(4'b0001 << out_sel)) != 4'b0000) viol++;
      if (out_valid && out_ready)
         log_q.push_back('{d: out_data, sel: out_sel, sop: out_sop, eop: out_eop, cyc: cyc});
      for (int i = 0; i < NR; i++)
         if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
      if (done && done_cyc < 0) done_cyc = cyc;
      cyc++;
      @(posedge clk);
   endtask

   task automatic run_until(input int n, input int bound, input string tag);
      int k = 0;
      while (log_q.size() < n && k < bound) begin
         cycle();
         k++;
      end
      chk(tag, log_q.size(), n);
   endtask

   task automatic start();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      log_q.delete();
      done_cyc = -1;
   endtask

   initial begin
      logic [31:0] v;
      int          cnt;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_flags", {done, err_oversize, out_sop, out_eop, req_done}, 0);
      chk("rst_sel_data", {out_sel, out_data}, 0);
      rst_n = 1'b1;
      cycle();

      // Single requester, header 3 and three payload beats
      src_q[2] = '{17'd3, 17'h10, 17'h11, 17'h12};
      start();
      run_until(4, 30, "t1_count");
      v = 0;
      for (int i = 0; i < 4; i++) v = v | ({30'd0, log_q[i].sel} << (2*i));
      chk("t1_sel", v, 32'h000000AA);
      chk("t1_data", {log_q[1].d[7:0], log_q[2].d[7:0], log_q[3].d[7:0]}, 32'h00101112);
      chk("t1_hdr", log_q[0].d, 3);
      chk("t1_sop", {log_q[3].sop, log_q[2].sop, log_q[1].sop, log_q[0].sop}, 4'b0001);
      chk("t1_eop", {log_q[3].eop, log_q[2].eop, log_q[1].eop, log_q[0].eop}, 4'b1000);
      cycle();
      chk("t1_req_done", req_done, 4'b0100);
      chk("t1_done", done, 0);

      // All four requesters, header 1 + one payload each
      for (int i = 0; i < NR; i++) src_q[i] = '{17'd1, 17'(17'h100 + i)};
      start();
      run_until(8, 60, "t2_count");
      v = 0;
      for (int i = 0; i < 8; i++) v = v | ({30'd0, log_q[i].sel} << (2*i));
      chk("t2_order", v, 32'h0000FA50);
      chk("t2_bubble01", log_q[2].cyc - log_q[1].cyc, 2);
      chk("t2_bubble23", log_q[6].cyc - log_q[5].cyc, 2);
      chk("t2_pair", log_q[7].cyc - log_q[6].cyc, 1);
      chk("t2_last_data", log_q[7].d, 17'h103);
      cycle();
      chk("t2_done_cycle", done_cyc, log_q[7].cyc + 1);
      chk("t2_req_done", req_done, 4'hF);
      chk("t2_err", err_oversize, 0);
      src_q[0] = '{17'd1, 17'd2};
      repeat (3) cycle();
      chk("t2_done_hold", {s_valid, s_rdy}, 0);
      src_q[0].delete();

      // Zero-size header, then requester 1 after one ARB bubble
      src_q[0] = '{17'd0};
      src_q[1] = '{17'd1, 17'h55};
      start();
      run_until(3, 30, "t3_count");
      chk("t3_sop_eop", {log_q[0].sel, log_q[0].sop, log_q[0].eop}, 4'b0011);
      chk("t3_next_sel", log_q[1].sel, 1);
      chk("t3_bubble", log_q[1].cyc - log_q[0].cyc, 2);
      cycle();
      chk("t3_req_done", req_done, 4'b0011);

      // Random sink backpressure over a 5-beat body
      src_q[3] = '{17'd5, 17'h21, 17'h22, 17'h23, 17'h24, 17'h25};
      start();
      rand_rdy = 1'b1;
      run_until(6, 200, "t4_count");
      rand_rdy = 1'b0;
      repeat (4) cycle();
      chk("t4_no_dup", log_q.size(), 6);
      v = 0;
      for (int i = 1; i < 6; i++) v = v | ({24'd0, log_q[i].d[7:0]} << (8*(i-1)));
      chk("t4_data_lo", v, 32'h24232221);
      chk("t4_data_hi", log_q[5].d, 17'h25);
      v = 0;
      for (int i = 0; i < 6; i++) v = v | ({31'd0, log_q[i].eop} << i);
      chk("t4_eop", v, 6'b100000);

      // Header exactly MAX_SIZE is legal; 3000 is oversize but still runs full length
      src_q[0].push_back(17'd2048);
      for (int i = 0; i < 2048; i++) src_q[0].push_back(17'(i));
      start();
      run_until(2049, 2300, "t5_max_count");
      cycle();
      chk("t5_max_err", err_oversize, 0);
      log_q.delete();
      src_q[1].push_back(17'd3000);
      for (int i = 0; i < 3000; i++) src_q[1].push_back(17'(i + 7));
      run_until(3001, 3300, "t5_over_count");
      cnt = 0;
      for (int i = 1; i < 3001; i++) if (log_q[i].d !== 17'(i + 6) || log_q[i].sel !== 2'd1) cnt++;
      chk("t5_payload", cnt, 0);
      cnt = 0;
      for (int i = 0; i < 3001; i++) cnt += log_q[i].eop;
      chk("t5_eop_count", cnt, 1);
      chk("t5_eop_last", log_q[3000].eop, 1);
      cycle();
      chk("t5_err", err_oversize, 1);
      chk("t5_req_done", req_done, 4'b0011);

      // Flush while body beat 2 of 4 is presented
      src_q[2] = '{17'd4, 17'h41, 17'h42, 17'h43, 17'h44};
      start();
      chk("t6_err_cleared", err_oversize, 0);
      run_until(2, 30, "t6_pre");
      flush = 1'b1;
      cycle();
      chk("t6_flush_valid", s_valid, 0);
      chk("t6_flush_ready", s_rdy, 0);
      chk("t6_no_hs", log_q.size(), 2);
      flush = 1'b0;
      src_q[2].delete();
      cycle();
      chk("t6_cleared", {done, req_done}, 0);
      log_q.delete();
      src_q[1] = '{17'd1, 17'h31};
      src_q[3] = '{17'd1, 17'h33};
      run_until(4, 40, "t6_restart");
      chk("t6_first_sel", log_q[0].sel, 1);
      chk("t6_second_sel", log_q[2].sel, 3);

      // Asynchronous reset mid-block
      src_q[2] = '{17'd2, 17'h61, 17'h62};
      start();
      run_until(2, 30, "t7_pre");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", {out_valid, req_ready}, 0);
      chk("t7_rst_sel", out_sel, 0);
      @(posedge clk);
      rst_n = 1'b1;
      src_q[2].delete();

      chk("ready_onehot", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
